// File: rtl/approx_adder_monitor_pkg.sv
// Shared definitions for the approximate adder monitor: mode encoding, adaptive
// FSM states and the lower-part-OR (LOA) approximate sum.
package approx_adder_monitor_pkg;

   localparam logic [1:0] MODE_EXACT  = 2'b00;
   localparam logic [1:0] MODE_APPROX = 2'b01;
   localparam logic [1:0] MODE_ADAPT  = 2'b10;

   typedef enum logic {
      ST_APPROX   = 1'b0,
      ST_FALLBACK = 1'b1
   } adapt_state_e;

   // Operands are zero-extended to this width before calling loa_sum.
   localparam int unsigned LOA_MAX_W = 64;

   // Low k bits are OR-ed; the upper part is added exactly with the AND of bit
   // k-1 as carry-in. k must be in 1..operand width.
   function automatic logic [LOA_MAX_W:0] loa_sum(
      input logic [LOA_MAX_W-1:0] a,
      input logic [LOA_MAX_W-1:0] b,
      input int unsigned          k
   );
      logic [LOA_MAX_W:0]   one;
      logic [LOA_MAX_W:0]   low_mask;
      logic [LOA_MAX_W:0]   upper;
      logic [LOA_MAX_W-1:0] lsb_mask;
      logic                 carry;
      one      = (LOA_MAX_W + 1)'(1);
      lsb_mask = LOA_MAX_W'(1);
      low_mask = (one << k) - one;
      carry    = |(((a & b) >> (k - 1)) & lsb_mask);
      upper    = {1'b0, a >> k} + {1'b0, b >> k} + {{LOA_MAX_W{1'b0}}, carry};
      return (upper << k) | ({1'b0, a | b} & low_mask);
   endfunction

endpackage

// File: rtl/approx_adder_monitor_stats.sv
// Error statistics and adaptive APPROX/FALLBACK controller, driven by the
// retire strobe of the output stage.
module approx_err_stats
   import approx_adder_monitor_pkg::*;
#(
   parameter int unsigned ERR_W    = 3,
   parameter int unsigned WIN      = 16,
   parameter int unsigned VIOL_MAX = 2,
   parameter int unsigned CNT_W    = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             retire_i,
   input  logic             adapt_i,
   input  logic [ERR_W-1:0] err_i,
   input  logic             viol_i,
   output logic [ERR_W-1:0] stat_max_err_o,
   output logic [CNT_W-1:0] stat_viol_cnt_o,
   output logic [CNT_W-1:0] stat_samples_o,
   output logic             fallback_o
);

   localparam int unsigned     WIN_W  = $clog2(WIN + 1);
   localparam int unsigned     VCNT_W = $clog2(VIOL_MAX + 1);
   localparam logic [WIN_W-1:0]  WIN_L  = WIN_W'(WIN);
   localparam logic [VCNT_W-1:0] VMAX_L = VCNT_W'(VIOL_MAX);

   adapt_state_e       state_q, state_d;
   logic [WIN_W-1:0]   win_q, win_d, win_inc;
   logic [VCNT_W-1:0]  wviol_q, wviol_d, wviol_inc;
   logic [CNT_W-1:0]   samples_q, viol_cnt_q;
   logic [ERR_W-1:0]   max_err_q;

   always_comb begin
      // NOTE: every signal written here is defaulted first, so no path can infer a latch.
      state_d   = state_q;
      win_d     = win_q;
      wviol_d   = wviol_q;
      win_inc   = win_q + WIN_W'(1);
      wviol_inc = wviol_q + VCNT_W'(viol_i);
      if (clr_i) begin
         state_d = ST_APPROX;
         win_d   = '0;
         wviol_d = '0;
      end else if (retire_i && adapt_i && state_q == ST_APPROX) begin
         // The violation of the closing sample is counted before the window restarts.
         if (wviol_inc >= VMAX_L) state_d = ST_FALLBACK;
         if (win_inc == WIN_L) begin
            win_d   = '0;
            wviol_d = '0;
         end else begin
            win_d   = win_inc;
            wviol_d = wviol_inc;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_APPROX;
         win_q   <= '0;
         wviol_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         wviol_q <= wviol_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samples_q  <= '0;
         viol_cnt_q <= '0;
         max_err_q  <= '0;
      end else if (clr_i) begin
         samples_q  <= '0;
         viol_cnt_q <= '0;
         max_err_q  <= '0;
      end else if (retire_i) begin
         if (samples_q != '1) samples_q <= samples_q + CNT_W'(1);
         if (viol_i && viol_cnt_q != '1) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
         if (err_i > max_err_q) max_err_q <= err_i;
      end
   end

   assign stat_max_err_o  = max_err_q;
   assign stat_viol_cnt_o = viol_cnt_q;
   assign stat_samples_o  = samples_q;
   assign fallback_o      = (state_q == ST_FALLBACK);

endmodule

// File: rtl/approx_adder_monitor.sv
// Two-stage valid/ready approximate adder that reports the error of every
// delivered sum and falls back to exact addition in adaptive mode.
module approx_adder_monitor
   import approx_adder_monitor_pkg::*;
#(
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned LOA_BITS = 1,
   parameter int unsigned ET       = 4,
   parameter int unsigned WIN      = 16,
   parameter int unsigned VIOL_MAX = 2,
   parameter int unsigned CNT_W    = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_err,
   output logic             out_viol,
   output logic [WIDTH:0]   stat_max_err,
   output logic [CNT_W-1:0] stat_viol_cnt,
   output logic [CNT_W-1:0] stat_samples,
   output logic             fallback_o
);

   localparam int unsigned SUM_W = WIDTH + 1;

   logic             fallback;
   logic             s2_load, accept, use_approx_d;
   logic [SUM_W-1:0] exact_d, approx_d;

   logic             s1_valid_q, s1_use_approx_q;
   logic [1:0]       s1_mode_q;
   logic [SUM_W-1:0] s1_exact_q, s1_approx_q;

   logic             s2_valid_q, s2_viol_q, s2_adapt_q, s2_viol_d;
   logic [SUM_W-1:0] s2_sum_q, s2_err_q, s2_sum_d, s2_err_d;

   // in_ready depends only on registered occupancy and out_ready, never on in_valid.
   assign s2_load  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;
   assign accept   = in_valid && in_ready;

   assign exact_d  = {1'b0, in_a} + {1'b0, in_b};
   assign approx_d = SUM_W'(loa_sum(LOA_MAX_W'(in_a), LOA_MAX_W'(in_b), LOA_BITS));
   assign use_approx_d = (mode_i == MODE_APPROX) || (mode_i == MODE_ADAPT && !fallback);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q      <= 1'b0;
         s1_use_approx_q <= 1'b0;
         s1_mode_q       <= MODE_EXACT;
         s1_exact_q      <= '0;
         s1_approx_q     <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (accept) begin
            s1_use_approx_q <= use_approx_d;
            s1_mode_q       <= mode_i;
            s1_exact_q      <= exact_d;
            s1_approx_q     <= approx_d;
         end
      end
   end

   always_comb begin
      s2_sum_d = s1_use_approx_q ? s1_approx_q : s1_exact_q;
      s2_err_d = '0;
      if (s1_use_approx_q)
         s2_err_d = (s1_approx_q >= s1_exact_q) ? s1_approx_q - s1_exact_q
                                                : s1_exact_q - s1_approx_q;
      s2_viol_d = (32'(s2_err_d) > ET);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_err_q   <= '0;
         s2_viol_q  <= 1'b0;
         s2_adapt_q <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sum_q   <= s2_sum_d;
            s2_err_q   <= s2_err_d;
            s2_viol_q  <= s2_viol_d;
            s2_adapt_q <= (s1_mode_q == MODE_ADAPT);
         end
      end
   end

   approx_err_stats #(
      .ERR_W    (SUM_W),
      .WIN      (WIN),
      .VIOL_MAX (VIOL_MAX),
      .CNT_W    (CNT_W)
   ) u_stats (
      .clk             (clk),
      .rst_n           (rst_n),
      .clr_i           (clr_i),
      .retire_i        (s2_valid_q && out_ready),
      .adapt_i         (s2_adapt_q),
      .err_i           (s2_err_q),
      .viol_i          (s2_viol_q),
      .stat_max_err_o  (stat_max_err),
      .stat_viol_cnt_o (stat_viol_cnt),
      .stat_samples_o  (stat_samples),
      .fallback_o      (fallback)
   );

   assign out_valid  = s2_valid_q;
   assign out_sum    = s2_sum_q;
   assign out_err    = s2_err_q;
   assign out_viol   = s2_viol_q;
   assign fallback_o = fallback;

endmodule

// File: tb/tb_approx_adder_monitor.sv
// Directed and randomized bench for approx_adder_monitor with a transaction-level
// reference model (scoreboard queue plus arithmetic statistics model).
module tb_approx_adder_monitor;

   localparam int WIDTH    = 2;
   localparam int LOA_BITS = 1;
   localparam int ET       = 0;
   localparam int WIN      = 4;
   localparam int VIOL_MAX = 2;
   localparam int CNT_W    = 3;
   localparam int SW       = WIDTH + 1;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk, rst_n;
   logic             in_valid, in_ready, clr_i, out_valid, out_ready, out_viol, fallback_o;
   logic [WIDTH-1:0] in_a, in_b;
   logic [1:0]       mode_i;
   logic [SW-1:0]    out_sum, out_err, stat_max_err;
   logic [CNT_W-1:0] stat_viol_cnt, stat_samples;

   approx_adder_monitor #(
      .WIDTH(WIDTH), .LOA_BITS(LOA_BITS), .ET(ET),
      .WIN(WIN), .VIOL_MAX(VIOL_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mode_i(mode_i), .clr_i(clr_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_err(out_err), .out_viol(out_viol), .stat_max_err(stat_max_err),
      .stat_viol_cnt(stat_viol_cnt), .stat_samples(stat_samples),
      .fallback_o(fallback_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int err;
      bit viol;
      bit adapt;
   } exp_t;

   exp_t sb[$];
   int   checks, errors;
   int   m_samples, m_viol, m_max, m_win, m_wv;
   bit   m_fb;
   bit   last_acc, last_ret;
   logic [SW-1:0] hold_sum, hold_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Approximate sum straight from the arithmetic definition of the LOA adder.
   function automatic int approx_ref(input int a, input int b);
      int kp, low, carry, upper;
      kp    = 1 << LOA_BITS;
      low   = (a % kp) | (b % kp);
      carry = ((a >> (LOA_BITS - 1)) & 1) & ((b >> (LOA_BITS - 1)) & 1);
      upper = (a / kp) + (b / kp) + carry;
      return upper * kp + low;
   endfunction

   task automatic model_clear();
      m_samples = 0; m_viol = 0; m_max = 0; m_win = 0; m_wv = 0; m_fb = 0;
   endtask

   task automatic model_retire(input exp_t e);
      if (m_samples < CNT_MAX) m_samples++;
      if (e.viol && m_viol < CNT_MAX) m_viol++;
      if (e.err > m_max) m_max = e.err;
      if (!m_fb && e.adapt) begin
         m_win++;
         if (e.viol) m_wv++;
         if (m_wv >= VIOL_MAX) m_fb = 1;
         if (m_win == WIN) begin
            m_win = 0;
            m_wv  = 0;
         end
      end
   endtask

   // One clock: observe handshakes mid-cycle, update the model, return just after the edge.
   task automatic tick();
      exp_t e;
      int   ex, ap;
      bit   use_ap;
      @(negedge clk);
      last_acc = in_valid && in_ready;
      last_ret = out_valid && out_ready;
      if (sb.size() == 0) check("idle_valid", out_valid, 0);
      if (last_acc) begin
         ex      = int'(in_a) + int'(in_b);
         ap      = approx_ref(int'(in_a), int'(in_b));
         use_ap  = (mode_i == 2'b01) || (mode_i == 2'b10 && !m_fb);
         e.sum   = use_ap ? ap : ex;
         e.err   = use_ap ? ((ap > ex) ? ap - ex : ex - ap) : 0;
         e.viol  = e.err > ET;
         e.adapt = (mode_i == 2'b10);
         sb.push_back(e);
      end
      if (last_ret && sb.size() != 0) begin
         e = sb.pop_front();
         check("out_sum", out_sum, e.sum);
         check("out_err", out_err, e.err);
         check("out_viol", out_viol, e.viol);
         if (!clr_i) model_retire(e);
      end
      if (clr_i) model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_samples"}, stat_samples, m_samples);
      check({tag, "_viol_cnt"}, stat_viol_cnt, m_viol);
      check({tag, "_max_err"}, stat_max_err, m_max);
      check({tag, "_fallback"}, fallback_o, m_fb);
   endtask

   task automatic send(input int a, input int b, input int m);
      in_a     = WIDTH'(a);
      in_b     = WIDTH'(b);
      mode_i   = 2'(m);
      in_valid = 1'b1;
      last_acc = 1'b0;
      for (int i = 0; i < 20 && !last_acc; i++) tick();
      check("send_accept", last_acc, 1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic clr_pulse();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired before the end of the test");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      model_clear();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_i = 1'b0;
      mode_i = 2'b00; in_a = '0; in_b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_viol", out_viol, 0);
      check_stats("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Approximate mode, two-cycle latency
      send(1, 1, 1);
      in_valid = 1'b0;
      check("lat_n1_valid", out_valid, 0);
      tick();
      check("lat_n2_valid", out_valid, 1);
      check("approx_11_sum", out_sum, 3);
      check("approx_11_err", out_err, 1);
      check("approx_11_viol", out_viol, 1);
      send(3, 3, 1);
      in_valid = 1'b0;
      tick();
      check("approx_33_sum", out_sum, 7);
      check("approx_33_err", out_err, 1);
      drain();
      check_stats("approx");

      // Exact mode over every operand pair
      clr_pulse();
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++) send(a, b, 0);
      drain();
      check("exact_max_err", stat_max_err, 0);
      check("exact_samples_sat", stat_samples, CNT_MAX);
      check_stats("exact");

      // Adaptive fallback; third sample keeps its in-flight approximate decision
      clr_pulse();
      send(1, 1, 2); send(1, 1, 2); send(1, 1, 2);
      drain();
      check("fb_set", fallback_o, 1);
      check("fb_viol_cnt", stat_viol_cnt, 3);
      send(1, 1, 2);
      in_valid = 1'b0;
      tick();
      check("fb_exact_sum", out_sum, 2);
      check("fb_exact_err", out_err, 0);
      drain();
      check_stats("fb");

      // Window restart keeps one violation per window
      clr_pulse();
      send(1, 1, 2); send(0, 0, 2); send(0, 0, 2); send(0, 0, 2); send(1, 1, 2);
      drain();
      check("win_fallback", fallback_o, 0);
      check("win_viol_cnt", stat_viol_cnt, 2);
      check_stats("win");

      // Output stall: held outputs, in_ready drops, nothing lost or duplicated
      clr_pulse();
      out_ready = 1'b0;
      mode_i = 2'b01; in_valid = 1'b1;
      in_a = 1; in_b = 1; tick();
      in_a = 2; in_b = 1; tick();
      in_a = 3; in_b = 3;
      check("stall_first_sum", out_sum, 3);
      hold_sum = out_sum;
      hold_err = out_err;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_sum_stable", out_sum, hold_sum);
         check("stall_err_stable", out_err, hold_err);
      end
      out_ready = 1'b1;
      tick();
      drain();
      check("stall_count", stat_samples, 3);
      check_stats("stall");

      // Counter saturation
      clr_pulse();
      for (int i = 0; i < 9; i++) send(i % 4, (i + 1) % 4, 0);
      drain();
      check("sat_samples", stat_samples, CNT_MAX);
      check("sat_viol_cnt", stat_viol_cnt, 0);

      // Clear coinciding with a retire that would have triggered fallback
      clr_pulse();
      send(1, 1, 2); send(1, 1, 2); send(1, 1, 2);
      in_valid = 1'b0;
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr_on_retire", last_ret, 1);
      check("clr_samples", stat_samples, 0);
      check("clr_viol_cnt", stat_viol_cnt, 0);
      check("clr_max_err", stat_max_err, 0);
      check("clr_fallback", fallback_o, 0);
      drain();
      check_stats("post_clr");

      // Randomized traffic with back-pressure and occasional clears
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_a      = WIDTH'($urandom);
         in_b      = WIDTH'($urandom);
         mode_i    = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_i     = ($urandom_range(0, 39) == 0);
         tick();
         check_stats("rnd");
      end
      clr_i = 1'b0;
      drain();
      check_stats("rnd_end");

      // Asynchronous reset mid-stream
      send(1, 1, 1); send(2, 2, 1); send(3, 1, 1);
      check("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      in_valid = 1'b0;
      sb.delete();
      model_clear();
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check_stats("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(2, 1, 1);
      drain();
      check_stats("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
